// File: rtl/gaussian_conv.sv
// 7x7 Gaussian blur (binomial weights 1,6,15,20,15,6,1) as a 4-stage pipeline
// with one global stall enable, plus a per-frame output counter that raises done.
module gaussian_conv #(
  parameter int BITS    = 8,
  parameter int WIDTH   = 7,
  parameter int ADDRLEN = 19,
  parameter int MASKLEN = 392,
  parameter int ROW     = 480,
  parameter int COL     = 640
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MASKLEN-1:0] in_window,
  input  logic [ADDRLEN-1:0] in_waddr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITS-1:0]    out_pixel,
  output logic [ADDRLEN-1:0] out_waddr,
  output logic               done
);

  // Handshake: a window is taken on in_valid && in_ready and a pixel is handed
  // off on out_valid && out_ready; in_ready drops only while a finished pixel
  // is blocked by out_ready=0, and then every stage holds.
  localparam int HW    = 16;
  localparam int SW    = 20;
  localparam int TOTAL = (ROW - WIDTH + 1) * (COL - WIDTH + 1);
  localparam logic [ADDRLEN-1:0] TOTAL_A = ADDRLEN'(TOTAL);

  function automatic logic [4:0] wgt(input int i);
    case (i)
      0, 6:    wgt = 5'd1;
      1, 5:    wgt = 5'd6;
      2, 4:    wgt = 5'd15;
      default: wgt = 5'd20;
    endcase
  endfunction

  function automatic logic [HW-1:0] row_sum(input logic [WIDTH*BITS-1:0] row);
    logic [HW-1:0] acc;
    acc = '0;
    for (int c = 0; c < WIDTH; c++) begin
      acc = acc + HW'(row[c*BITS +: BITS]) * HW'(wgt(c));
    end
    return acc;
  endfunction

  logic                en;
  logic                deliver;
  logic                v1_q, v2_q, v3_q, v4_q;
  logic [ADDRLEN-1:0]  a1_q, a2_q, a3_q, a4_q;
  logic [HW-1:0]       h1_q [WIDTH];
  logic [HW-1:0]       h_d  [WIDTH];
  logic [SW-1:0]       m2_q [WIDTH];
  logic [SW-1:0]       m_d  [WIDTH];
  logic [SW-1:0]       s3_q, s_d;
  logic [SW-1:0]       rnd;
  logic [BITS-1:0]     p4_q, p_d;
  logic [ADDRLEN-1:0]  cnt_q, cnt_d;
  logic                done_q, done_d;

  assign en        = !(v4_q && !out_ready);
  assign in_ready  = en;
  assign deliver   = v4_q && out_ready;
  assign out_valid = v4_q;
  assign out_pixel = p4_q;
  assign out_waddr = a4_q;
  assign done      = done_q;

  always_comb begin
    for (int r = 0; r < WIDTH; r++) begin
      h_d[r] = row_sum(in_window[r*WIDTH*BITS +: WIDTH*BITS]);
      m_d[r] = SW'(h1_q[r]) * SW'(wgt(r));
    end
    s_d = '0;
    for (int r = 0; r < WIDTH; r++) begin
      s_d = s_d + m2_q[r];
    end
    // Max sum is 255*4096, so adding the half-LSB still fits in SW bits.
    rnd = s3_q + SW'(2048);
    p_d = rnd[12 +: BITS];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0;
      a1_q <= '0;   a2_q <= '0;   a3_q <= '0;   a4_q <= '0;
      for (int r = 0; r < WIDTH; r++) begin
        h1_q[r] <= '0;
        m2_q[r] <= '0;
      end
      s3_q <= '0;
      p4_q <= '0;
    end else if (en) begin
      v1_q <= in_valid; a1_q <= in_waddr; h1_q <= h_d;
      v2_q <= v1_q;     a2_q <= a1_q;     m2_q <= m_d;
      v3_q <= v2_q;     a3_q <= a2_q;     s3_q <= s_d;
      v4_q <= v3_q;     a4_q <= a3_q;     p4_q <= p_d;
    end
  end

  // frame_start has priority over a coincident deliver; counting freezes once done.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (frame_start) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (deliver && !done_q) begin
      cnt_d = cnt_q + ADDRLEN'(1);
      if (cnt_d == TOTAL_A) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_gaussian_conv.sv
// Directed bench for gaussian_conv: hand-computed pixels, latency, streaming,
// stall hold, done counting on a small 9x10 frame, and mid-flight reset.
module tb_gaussian_conv;
  localparam int BITS    = 8;
  localparam int WIDTH   = 7;
  localparam int ADDRLEN = 19;
  localparam int MASKLEN = 392;
  localparam int ROW     = 9;
  localparam int COL     = 10;
  localparam int PW      = ADDRLEN + BITS;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               frame_start = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [MASKLEN-1:0] in_window = '0;
  logic [ADDRLEN-1:0] in_waddr = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [BITS-1:0]    out_pixel;
  logic [ADDRLEN-1:0] out_waddr;
  logic               done;

  int checks   = 0;
  int failures = 0;
  logic [PW-1:0] exp_q[$];

  gaussian_conv #(
    .BITS(BITS), .WIDTH(WIDTH), .ADDRLEN(ADDRLEN), .MASKLEN(MASKLEN), .ROW(ROW), .COL(COL)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window), .in_waddr(in_waddr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_waddr(out_waddr), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MASKLEN-1:0] fill_win(input logic [7:0] v);
    logic [MASKLEN-1:0] w;
    for (int i = 0; i < 49; i++) w[i*8 +: 8] = v;
    return w;
  endfunction

  function automatic logic [MASKLEN-1:0] set_px(input logic [MASKLEN-1:0] w, input int r,
                                                input int c, input logic [7:0] v);
    w[(r*7+c)*8 +: 8] = v;
    return w;
  endfunction

  // driver: one window, checks 4-cycle latency, pixel, address and handoff
  task automatic send_one(input logic [MASKLEN-1:0] win, input logic [ADDRLEN-1:0] addr,
                          input logic [BITS-1:0] exp_pix, input string tag);
    int lat;
    in_window = win;
    in_waddr  = addr;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'd4);
    check_eq({tag, " pixel"}, 32'(out_pixel), 32'(exp_pix));
    check_eq({tag, " waddr"}, 32'(out_waddr), 32'(addr));
    tick();
    check_eq({tag, " drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // driver + scoreboard: uniform windows (value v filters to exactly v)
  task automatic run_stream(input int n, input int stall_at, input int stall_len,
                            input int base, input string tag);
    int sent = 0;
    int cyc = 0;
    int got = 0;
    int first = -1;
    int last = -1;
    logic [7:0] v;
    logic [ADDRLEN-1:0] a;
    while ((sent < n || exp_q.size() > 0) && cyc < 300) begin
      out_ready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      v = 8'(((base + sent) * 37 + 5) % 256);
      a = ADDRLEN'(base + sent);
      in_valid  = (sent < n);
      in_window = fill_win(v);
      in_waddr  = a;
      #1;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq({tag, " unexpected output"}, 32'd1, 32'd0);
          end else begin
            check_eq({tag, " out"}, 32'({out_waddr, out_pixel}), 32'(exp_q.pop_front()));
          end
          got++;
          if (first < 0) first = cyc;
          last = cyc;
        end else begin
          check_eq({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
          if (exp_q.size() > 0)
            check_eq({tag, " stall hold"}, 32'({out_waddr, out_pixel}), 32'(exp_q[0]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({a, v});
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq({tag, " count"}, 32'(got), 32'(n));
    check_eq({tag, " leftover"}, 32'(exp_q.size()), 32'd0);
    if (stall_len == 0) check_eq({tag, " consecutive"}, 32'(last - first), 32'(n - 1));
  endtask

  initial begin
    logic [MASKLEN-1:0] win;
    int seen;

    // reset state
    repeat (2) tick();
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst out_pixel", 32'(out_pixel), 32'd0);
    check_eq("rst out_waddr", 32'(out_waddr), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("post-rst in_ready", 32'(in_ready), 32'd1);
    tick();

    // directed pixels
    send_one(fill_win(8'd255), 19'd1923, 8'd255, "all255");
    send_one(fill_win(8'd0), 19'd7, 8'd0, "all0");
    send_one(set_px(fill_win(8'd0), 3, 3, 8'd255), 19'd11, 8'd25, "centre");
    send_one(set_px(fill_win(8'd0), 0, 0, 8'd255), 19'd12, 8'd0, "corner");
    win = fill_win(8'd0);
    for (int c = 0; c < 7; c++) win = set_px(win, 0, c, 8'd255);
    send_one(win, 19'd13, 8'd4, "toprow");
    win = fill_win(8'd0);
    for (int c = 0; c < 7; c++) win = set_px(win, 3, c, 8'd255);
    send_one(win, 19'd14, 8'd80, "midrow");
    send_one(set_px(fill_win(8'd0), 3, 2, 8'd255), 19'd15, 8'd19, "px32");
    send_one(fill_win(8'd100), 19'd524287, 8'd100, "all100");

    // done on the 12th deliver of a 9x10 frame, sticky, cleared by frame_start
    pulse_frame_start();
    check_eq("fs clears done", 32'(done), 32'd0);
    for (int i = 0; i < 12; i++) begin
      send_one(fill_win(8'(i + 1)), 19'(i), 8'(i + 1), "frame1");
      check_eq("frame1 done", 32'(done), 32'(i == 11));
    end
    send_one(fill_win(8'd9), 19'd99, 8'd9, "extra");
    check_eq("done sticky", 32'(done), 32'd1);
    pulse_frame_start();
    check_eq("fs clears done2", 32'(done), 32'd0);
    for (int i = 0; i < 12; i++) begin
      send_one(fill_win(8'(200 - i)), 19'(i + 40), 8'(200 - i), "frame2");
      check_eq("frame2 done", 32'(done), 32'(i == 11));
    end

    // streaming and stall
    run_stream(20, 0, 0, 1000, "stream");
    run_stream(15, 6, 10, 2000, "stall");

    // reset with data in flight
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_window = fill_win(8'(50 + i));
      in_waddr  = 19'(3000 + i);
      tick();
    end
    in_valid = 1'b0;
    check_eq("inflight out_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("midrst out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst out_pixel", 32'(out_pixel), 32'd0);
    check_eq("midrst out_waddr", 32'(out_waddr), 32'd0);
    check_eq("midrst done", 32'(done), 32'd0);
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check_eq("no stale output", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
